// File: rtl/ttl_pkg.sv
// Shared types and elaboration helpers for the ttl_counter family.
package ttl_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // Number of bits needed to hold values 0..v-1; used to validate MODULUS against WIDTH.
   function automatic int ttl_clog2(input longint unsigned v);
      int r;
      r = 0;
      for (int i = 0; i < 63; i++) begin
         if ((64'd1 << i) < v) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ttl_counter_next.sv
// Combinational next-count, terminal detection and wrap detection for ttl_counter_n.
module ttl_counter_next
   import ttl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q_i,
   input  dir_e             up_i,
   input  logic             stop_i,
   input  logic [WIDTH:0]   modulus_i,
   output logic [WIDTH-1:0] next_o,
   output logic             at_terminal_o,
   output logic             wrap_event_o
);

   logic [WIDTH-1:0] term_max_s;

   // modulus = 2**WIDTH truncates to all ones here, which is the right top value
   assign term_max_s = WIDTH'(modulus_i - (WIDTH+1)'(1));

   // Out-of-range values at or above the top count as terminal when counting up.
   always_comb begin
      at_terminal_o = 1'b0;
      next_o        = q_i;
      wrap_event_o  = 1'b0;
      if (up_i == DIR_UP) begin
         at_terminal_o = (q_i >= term_max_s);
      end else begin
         at_terminal_o = (q_i == {WIDTH{1'b0}});
      end
      if (!at_terminal_o) begin
         next_o = (up_i == DIR_UP) ? (q_i + WIDTH'(1)) : (q_i - WIDTH'(1));
      end else if (stop_i) begin
         next_o = q_i;
      end else begin
         next_o       = (up_i == DIR_UP) ? {WIDTH{1'b0}} : term_max_s;
         wrap_event_o = 1'b1;
      end
   end

endmodule

// File: rtl/ttl_counter_n.sv
// Parametrised cascadable binary counter with clear, load, up/down, stop-at-terminal and wrap pulse.
module ttl_counter_n
   import ttl_pkg::*;
#(
   parameter int              WIDTH   = 8,
   parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
   input  logic             CLK,
   input  logic             CLRB,
   input  logic             SRB,
   input  logic             LOADB,
   input  logic [WIDTH-1:0] D,
   input  logic             ENP,
   input  logic             ENT,
   input  logic             UP,
   input  logic             STOP,
   output logic [WIDTH-1:0] Q,
   output logic             CO,
   output logic             WRAP
);

   localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("ttl_counter_n: WIDTH must be 1..32");
   end
   if (MODULUS < 64'd2 || ttl_clog2(MODULUS) > WIDTH) begin : g_bad_modulus
      $error("ttl_counter_n: MODULUS must be within 2..2**WIDTH");
   end

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] next_s;
   logic             at_terminal_s;
   logic             wrap_event_s;

   ttl_counter_next #(.WIDTH(WIDTH)) u_next (
      .q_i          (q_q),
      .up_i         (dir_e'(UP)),
      .stop_i       (STOP),
      .modulus_i    (MOD_W),
      .next_o       (next_s),
      .at_terminal_o(at_terminal_s),
      .wrap_event_o (wrap_event_s)
   );

   // Clear beats load beats count; WRAP only pulses on an enabled wrapping count.
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (!SRB) begin
         q_d = {WIDTH{1'b0}};
      end else if (!LOADB) begin
         q_d = D;
      end else if (ENP && ENT) begin
         q_d    = next_s;
         wrap_d = wrap_event_s;
      end else begin
         q_d = q_q;
      end
   end

   // Count and wrap registers, asynchronously cleared by CLRB.
   always_ff @(posedge CLK or negedge CLRB) begin
      if (!CLRB) begin
         q_q    <= {WIDTH{1'b0}};
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign Q    = q_q;
   assign WRAP = wrap_q;
   // CO is the only combinational path; it carries the cascade ripple.
   assign CO   = ENT & at_terminal_s;

endmodule
